alu_op_decoder: RTL and testbench

//  Decode-stage block and producer of the execute-stage ALU control. Accepts one RV32I

---
 rtl/riscv_alu_pkg.sv | 84 ++++++++
 rtl/imm_gen.sv | 36 +++
 rtl/alu_op_decoder.sv | 198 +++++++++++++++++++
 tb/tb_alu_op_decoder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_alu_pkg.sv
// Shared RV32I decode constants and the ALU op-code encoding used by decode and execute.
package riscv_alu_pkg;

  localparam int XLEN     = 32;
  localparam int ALU_OP_W = 5;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_NOP  = 5'b00000,
    ALU_ADD  = 5'b00001,
    ALU_SUB  = 5'b00010,
    ALU_SLL  = 5'b00011,
    ALU_SLT  = 5'b00100,
    ALU_SLTU = 5'b00101,
    ALU_XOR  = 5'b00110,
    ALU_SRL  = 5'b00111,
    ALU_SRA  = 5'b01000,
    ALU_OR   = 5'b01001,
    ALU_AND  = 5'b01010,
    ALU_JALR = 5'b01011,
    ALU_BEQ  = 5'b01100,
    ALU_BNE  = 5'b01101,
    ALU_BLT  = 5'b01110,
    ALU_BGE  = 5'b01111,
    ALU_BLTU = 5'b10000,
    ALU_BGEU = 5'b10001,
    ALU_JAL  = 5'b10010
  } alu_op_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    FMT_NONE, FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J
  } fmt_e;

  // One ID/EX bundle; the all-zero value is the reset/flush value (op = ALU_NOP).
  typedef struct packed {
    alu_op_e         op;
    logic [4:0]      shamt;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            rd_write;
    logic            src1_pc;
    logic            src2_imm;
    logic            mem_read;
    logic            mem_write;
    logic            illegal;
    logic [XLEN-1:0] pc;
  } dec_bundle_t;

endpackage

// File: rtl/imm_gen.sv
// Instruction-format classification and sign-extended immediate extraction (pure combinational).
module imm_gen
  import riscv_alu_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  output fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  // NOTE: every variable written in an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    fmt = FMT_NONE;
    case (instr[6:0])
      OPC_OP:                         fmt = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: fmt = FMT_I;
      OPC_STORE:                      fmt = FMT_S;
      OPC_BRANCH:                     fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
      OPC_JAL:                        fmt = FMT_J;
      default:                        fmt = FMT_NONE;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/alu_op_decoder.sv
// RV32I decode stage: decodes one instruction per handshake into a registered ID/EX ALU bundle.
// Optional build macro DECODER_ILLEGAL_TRAP_EN flags unsupported encodings on the ILLEGAL output.
module alu_op_decoder
  import riscv_alu_pkg::*;
#(
  parameter int INPUT_WIDTH = XLEN,
  parameter int OP_WIDTH    = ALU_OP_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   instr_valid,
  output logic                   instr_ready,
  input  logic [INPUT_WIDTH-1:0] instr,
  input  logic [INPUT_WIDTH-1:0] pc_in,
  input  logic                   flush,
  output logic                   dec_valid,
  input  logic                   dec_ready,
  output logic [OP_WIDTH-1:0]    alu_instruction,
  output logic [4:0]             shift_amount,
  output logic [INPUT_WIDTH-1:0] immediate,
  output logic [4:0]             rs1_addr,
  output logic [4:0]             rs2_addr,
  output logic [4:0]             rd_addr,
  output logic                   rd_write,
  output logic                   alu_src1_pc,
  output logic                   alu_src2_imm,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [INPUT_WIDTH-1:0] pc_out,
  output logic                   illegal
);

  fmt_e            fmt;
  logic [XLEN-1:0] imm;
  dec_bundle_t     dec;
  dec_bundle_t     dec_q;
  logic            dec_valid_q;
  logic            legal;
  logic            accept;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  imm_gen u_imm_gen (
    .instr (instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  always_comb begin
    dec      = '0;
    legal    = 1'b1;
    dec.pc   = pc_in;
    case (opcode)
      OPC_OP: begin
        case (funct3)
          F3_ADD_SUB: dec.op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL:     dec.op = ALU_SLL;
          F3_SLT:     dec.op = ALU_SLT;
          F3_SLTU:    dec.op = ALU_SLTU;
          F3_XOR:     dec.op = ALU_XOR;
          F3_SRL_SRA: dec.op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          F3_OR:      dec.op = ALU_OR;
          F3_AND:     dec.op = ALU_AND;
          default:    dec.op = ALU_NOP;
        endcase
        // Only ADD/SUB and SRL/SRA have an alternate funct7 encoding.
        legal = (funct7 == F7_BASE) ||
                ((funct7 == F7_ALT) && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
      end
      OPC_OP_IMM: begin
        dec.src2_imm = 1'b1;
        case (funct3)
          F3_ADD_SUB: dec.op = ALU_ADD;
          F3_SLT:     dec.op = ALU_SLT;
          F3_SLTU:    dec.op = ALU_SLTU;
          F3_XOR:     dec.op = ALU_XOR;
          F3_OR:      dec.op = ALU_OR;
          F3_AND:     dec.op = ALU_AND;
          F3_SLL: begin
            dec.op    = ALU_SLL;
            dec.shamt = instr[24:20];
            legal     = (funct7 == F7_BASE);
          end
          F3_SRL_SRA: begin
            dec.op    = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.shamt = instr[24:20];
            legal     = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          end
          default: dec.op = ALU_NOP;
        endcase
      end
      OPC_LOAD: begin
        dec.op       = ALU_ADD;
        dec.src2_imm = 1'b1;
        dec.mem_read = 1'b1;
        legal        = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      end
      OPC_STORE: begin
        dec.op        = ALU_ADD;
        dec.src2_imm  = 1'b1;
        dec.mem_write = 1'b1;
        legal         = funct3 inside {3'b000, 3'b001, 3'b010};
      end
      OPC_BRANCH: begin
        case (funct3)
          F3_BEQ:  dec.op = ALU_BEQ;
          F3_BNE:  dec.op = ALU_BNE;
          F3_BLT:  dec.op = ALU_BLT;
          F3_BGE:  dec.op = ALU_BGE;
          F3_BLTU: dec.op = ALU_BLTU;
          F3_BGEU: dec.op = ALU_BGEU;
          default: legal  = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.op       = ALU_ADD;
        dec.src2_imm = 1'b1;
      end
      OPC_AUIPC: begin
        dec.op       = ALU_ADD;
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
      end
      OPC_JAL: begin
        dec.op       = ALU_JAL;
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
      end
      OPC_JALR: begin
        dec.op       = ALU_JALR;
        dec.src1_pc  = 1'b1;
        dec.src2_imm = 1'b1;
        legal        = (funct3 == 3'b000);
      end
      OPC_MISC_MEM: legal = (funct3 == 3'b000);
      OPC_SYSTEM:   legal = (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
      default:      legal = 1'b0;
    endcase

    // Register fields follow the format, so unused indices (incl. LUI rs1) read as 0.
    if (legal) begin
      dec.imm      = imm;
      dec.rs1      = (fmt inside {FMT_R, FMT_I, FMT_S, FMT_B}) ? instr[19:15] : 5'd0;
      dec.rs2      = (fmt inside {FMT_R, FMT_S, FMT_B}) ? instr[24:20] : 5'd0;
      dec.rd       = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) ? instr[11:7] : 5'd0;
      dec.rd_write = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (instr[11:7] != 5'd0);
    end else begin
      dec    = '0;
      dec.pc = pc_in;
    end

`ifdef DECODER_ILLEGAL_TRAP_EN
    dec.illegal = !legal;
`else
    dec.illegal = 1'b0;
`endif
  end

  assign instr_ready = !dec_valid_q || dec_ready;
  assign accept      = instr_valid && instr_ready && !flush;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
    end else if (flush) begin
      dec_q       <= '0;
      dec_valid_q <= 1'b0;
    end else if (accept) begin
      dec_q       <= dec;
      dec_valid_q <= 1'b1;
    end else if (dec_ready) begin
      dec_valid_q <= 1'b0;
    end
  end

  assign dec_valid       = dec_valid_q;
  assign alu_instruction = dec_q.op;
  assign shift_amount    = dec_q.shamt;
  assign immediate       = dec_q.imm;
  assign rs1_addr        = dec_q.rs1;
  assign rs2_addr        = dec_q.rs2;
  assign rd_addr         = dec_q.rd;
  assign rd_write        = dec_q.rd_write;
  assign alu_src1_pc     = dec_q.src1_pc;
  assign alu_src2_imm    = dec_q.src2_imm;
  assign mem_read        = dec_q.mem_read;
  assign mem_write       = dec_q.mem_write;
  assign pc_out          = dec_q.pc;
  assign illegal         = dec_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Self-checking bench for alu_op_decoder: hand-decoded expectation table feeding a scoreboard queue.
module tb_alu_op_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc_in;
  logic        flush;
  logic        dec_valid;
  logic        dec_ready;
  logic [4:0]  alu_instruction;
  logic [4:0]  shift_amount;
  logic [31:0] immediate;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic        rd_write;
  logic        alu_src1_pc;
  logic        alu_src2_imm;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] pc_out;
  logic        illegal;

`ifdef DECODER_ILLEGAL_TRAP_EN
  localparam logic ILL_EXP = 1'b1;
`else
  localparam logic ILL_EXP = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rdw;
    logic        s1pc;
    logic        s2imm;
    logic        mr;
    logic        mw;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  localparam int NW = 20;
  logic [31:0] words [NW] = '{
    32'hFFD08293, 32'h40725193, 32'h003100B3, 32'h40628233, 32'h00812383,
    32'hFE312E23, 32'h00208463, 32'hFE41C8E3, 32'h12345537, 32'hFFFFF597,
    32'hFFFFF0EF, 32'h00008067, 32'h01F11113, 32'h407352B3, 32'h0050F013,
    32'h00000073, 32'h00100073, 32'h0FF0000F, 32'hFFFFFFFF, 32'h402091B3
  };

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  logic m_valid = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  alu_op_decoder dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .pc_in           (pc_in),
    .flush           (flush),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .alu_instruction (alu_instruction),
    .shift_amount    (shift_amount),
    .immediate       (immediate),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rd_addr         (rd_addr),
    .rd_write        (rd_write),
    .alu_src1_pc     (alu_src1_pc),
    .alu_src2_imm    (alu_src2_imm),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .pc_out          (pc_out),
    .illegal         (illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [4:0] op, input logic [4:0] shamt, input logic [31:0] imm,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                              input logic rdw, input logic s1pc, input logic s2imm,
                              input logic mr, input logic mw);
    exp_t e;
    e = '{op: op, shamt: shamt, imm: imm, rs1: rs1, rs2: rs2, rd: rd, rdw: rdw, s1pc: s1pc,
          s2imm: s2imm, mr: mr, mw: mw, ill: 1'b0, pc: 32'h0};
    return e;
  endfunction

  // Hand-decoded expectations for every word in the stimulus table.
  function automatic exp_t golden(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    e = '0;
    case (w)
      32'hFFD08293: e = mk(5'd1,  5'd0,  32'hFFFFFFFD, 5'd1, 5'd0, 5'd5,  1, 0, 1, 0, 0);
      32'h40725193: e = mk(5'd8,  5'd7,  32'h00000407, 5'd4, 5'd0, 5'd3,  1, 0, 1, 0, 0);
      32'h003100B3: e = mk(5'd1,  5'd0,  32'h00000000, 5'd2, 5'd3, 5'd1,  1, 0, 0, 0, 0);
      32'h40628233: e = mk(5'd2,  5'd0,  32'h00000000, 5'd5, 5'd6, 5'd4,  1, 0, 0, 0, 0);
      32'h00812383: e = mk(5'd1,  5'd0,  32'h00000008, 5'd2, 5'd0, 5'd7,  1, 0, 1, 1, 0);
      32'hFE312E23: e = mk(5'd1,  5'd0,  32'hFFFFFFFC, 5'd2, 5'd3, 5'd0,  0, 0, 1, 0, 1);
      32'h00208463: e = mk(5'd12, 5'd0,  32'h00000008, 5'd1, 5'd2, 5'd0,  0, 0, 0, 0, 0);
      32'hFE41C8E3: e = mk(5'd14, 5'd0,  32'hFFFFFFF0, 5'd3, 5'd4, 5'd0,  0, 0, 0, 0, 0);
      32'h12345537: e = mk(5'd1,  5'd0,  32'h12345000, 5'd0, 5'd0, 5'd10, 1, 0, 1, 0, 0);
      32'hFFFFF597: e = mk(5'd1,  5'd0,  32'hFFFFF000, 5'd0, 5'd0, 5'd11, 1, 1, 1, 0, 0);
      32'hFFFFF0EF: e = mk(5'd18, 5'd0,  32'hFFFFFFFE, 5'd0, 5'd0, 5'd1,  1, 1, 1, 0, 0);
      32'h00008067: e = mk(5'd11, 5'd0,  32'h00000000, 5'd1, 5'd0, 5'd0,  0, 1, 1, 0, 0);
      32'h01F11113: e = mk(5'd3,  5'd31, 32'h0000001F, 5'd2, 5'd0, 5'd2,  1, 0, 1, 0, 0);
      32'h407352B3: e = mk(5'd8,  5'd0,  32'h00000000, 5'd6, 5'd7, 5'd5,  1, 0, 0, 0, 0);
      32'h0050F013: e = mk(5'd10, 5'd0,  32'h00000005, 5'd1, 5'd0, 5'd0,  0, 0, 1, 0, 0);
      32'hFFFFFFFF, 32'h402091B3: e.ill = ILL_EXP;
      default: e = '0;
    endcase
    e.pc = pc;
    return e;
  endfunction

  task automatic check_bundle(input exp_t e);
    check("alu_instruction", alu_instruction, e.op);
    check("shift_amount", shift_amount, e.shamt);
    check("immediate", immediate, e.imm);
    check("rs1_addr", rs1_addr, e.rs1);
    check("rs2_addr", rs2_addr, e.rs2);
    check("rd_addr", rd_addr, e.rd);
    check("rd_write", rd_write, e.rdw);
    check("alu_src1_pc", alu_src1_pc, e.s1pc);
    check("alu_src2_imm", alu_src2_imm, e.s2imm);
    check("mem_read", mem_read, e.mr);
    check("mem_write", mem_write, e.mw);
    check("illegal", illegal, e.ill);
    check("pc_out", pc_out, e.pc);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_dec_valid"}, dec_valid, 0);
    check_bundle('0);
  endtask

  // One clock cycle: drive inputs just after a negedge, compare before the posedge, update the model.
  task automatic cycle(input logic v, input logic [31:0] w, input logic f, input logic r);
    instr_valid = v;
    instr       = w;
    pc_in       = pc_ctr;
    flush       = f;
    dec_ready   = r;
    pc_ctr      = pc_ctr + 32'd4;
    #1;
    check("instr_ready", instr_ready, !m_valid || r);
    check("dec_valid", dec_valid, m_valid);
    if (m_valid && sb_q.size() > 0) begin
      check_bundle(sb_q[0]);
      if (r || f) void'(sb_q.pop_front());
    end
    if (v && (!m_valid || r) && !f) begin
      sb_q.push_back(golden(w, pc_in));
      m_valid = 1'b1;
    end else if (f || r) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    pc_in       = '0;
    flush       = 1'b0;
    dec_ready   = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    reset_n = 1'b1;

    // ADDI accepted, then held; asynchronous reset clears it mid-cycle without a clock edge.
    cycle(1, 32'hFFD08293, 0, 0);
    cycle(0, 32'h0, 0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    check_cleared("async_reset");
    m_valid = 1'b0;
    sb_q.delete();
    @(negedge clk);
    reset_n = 1'b1;

    // SRAI held for three cycles under backpressure, then back-to-back accepts.
    cycle(1, 32'h40725193, 0, 0);
    repeat (3) cycle(1, 32'h003100B3, 0, 0);
    cycle(1, 32'h003100B3, 0, 1);
    cycle(1, 32'h40628233, 0, 1);

    // Flush with an incoming BEQ: the held SUB is consumed, the BEQ never appears.
    cycle(1, 32'h00208463, 1, 1);
    #1;
    check_cleared("flush");
    cycle(0, 32'h0, 0, 1);

    // All-ones word: NOP bundle, ILLEGAL depending on build.
    cycle(1, 32'hFFFFFFFF, 0, 1);
    cycle(0, 32'h0, 0, 1);

    for (int i = 0; i < NW; i++) cycle(1, words[i], 0, 1);
    cycle(0, 32'h0, 0, 1);

    for (int n = 0; n < 300; n++) begin
      w = words[$urandom_range(0, NW - 1)];
      cycle(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) != 0));
    end

    repeat (3) cycle(0, 32'h0, 0, 1);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
